// File: rtl/reg_dump_sequencer_if.sv
// Byte-stream valid/ready link from the register dump sequencer to its TX sink.
// The master drives data/valid; the slave answers with ready.
interface reg_dump_sequencer_if #(
  parameter int unsigned NB_BYTE = 8
);
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/reg_dump_sequencer.sv
// Halted-pipeline register dump: owns RF read port 1 and streams every register MSB-first as bytes.
// Optional trailing XOR checksum byte when REG_DUMP_CHECKSUM_EN is defined.
module reg_dump_sequencer #(
  parameter int unsigned LEN                  = 32,
  parameter int unsigned CANTIDAD_REGISTROS   = 32,
  parameter int unsigned NB_ADDRESS_REGISTROS = $clog2(CANTIDAD_REGISTROS),
  parameter int unsigned NB_BYTE              = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic                            i_halted,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_rs_pipe,
  input  logic [LEN-1:0]                  i_read_data,
  output logic [NB_ADDRESS_REGISTROS-1:0] o_read_reg,
  output logic                            o_pipe_grant,
  reg_dump_sequencer_if.master            tx_if,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_abort
);

  localparam int unsigned NBYTES = LEN / NB_BYTE;
  localparam int unsigned NB_CNT = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [NB_CNT-1:0]               LAST_BYTE = NB_CNT'(NBYTES - 1);
  localparam logic [NB_ADDRESS_REGISTROS-1:0] LAST_REG  =
      NB_ADDRESS_REGISTROS'(CANTIDAD_REGISTROS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SELECT = 3'd1;
  localparam logic [2:0] SEND   = 3'd2;
  localparam logic [2:0] NEXT   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam logic [2:0] CHECK  = 3'd5;
`endif

  logic [2:0]                      r_state;
  logic [2:0]                      w_state_next;
  logic [NB_ADDRESS_REGISTROS-1:0] r_index;
  logic [NB_CNT-1:0]               r_byte_cnt;
  logic [LEN-1:0]                  r_shift;
  logic                            r_abort;
  logic                            w_tx_valid;
  logic                            w_hs;
  logic                            w_abort;
  logic                            w_last_byte;
  logic                            w_last_reg;
  logic [NB_BYTE-1:0]              w_cur_byte;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0]              r_csum;
`endif

  assign w_cur_byte  = r_shift[LEN-1 -: NB_BYTE];
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);
  assign w_last_reg  = (r_index == LAST_REG);

`ifdef REG_DUMP_CHECKSUM_EN
  assign w_tx_valid     = (r_state == SEND) || (r_state == CHECK);
  assign tx_if.tx_data  = (r_state == CHECK) ? r_csum : w_cur_byte;
`else
  assign w_tx_valid     = (r_state == SEND);
  assign tx_if.tx_data  = w_cur_byte;
`endif
  assign tx_if.tx_valid = w_tx_valid;
  assign w_hs           = w_tx_valid & tx_if.tx_ready;

  // DONE already reports completion, so losing i_halted there is not treated as an abort.
  assign w_abort = !i_halted && (r_state != IDLE) && (r_state != DONE);

  assign o_busy       = (r_state != IDLE);
  assign o_pipe_grant = !o_busy;
  assign o_done       = (r_state == DONE);
  assign o_abort      = r_abort;
  assign o_read_reg   = (r_state == IDLE) ? i_rs_pipe : r_index;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (i_start && i_halted) w_state_next = SELECT;
      SELECT: w_state_next = SEND;
      SEND:   if (w_hs && w_last_byte) w_state_next = NEXT;
`ifdef REG_DUMP_CHECKSUM_EN
      NEXT:   w_state_next = w_last_reg ? CHECK : SELECT;
      CHECK:  if (w_hs) w_state_next = DONE;
`else
      NEXT:   w_state_next = w_last_reg ? DONE : SELECT;
`endif
      DONE:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (w_abort) w_state_next = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_index    <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_abort <= w_abort;
      case (r_state)
        IDLE:   r_index <= '0;
        SELECT: begin
          r_shift    <= i_read_data;
          r_byte_cnt <= '0;
        end
        SEND: begin
          if (w_hs) begin
            r_shift    <= r_shift << NB_BYTE;
            r_byte_cnt <= r_byte_cnt + 1'b1;
          end
        end
        NEXT:   if (!w_last_reg) r_index <= r_index + 1'b1;
        DONE:   r_index <= '0;
        default: ;
      endcase
    end
  end

`ifdef REG_DUMP_CHECKSUM_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_csum <= '0;
    end else if (r_state == IDLE && i_start && i_halted) begin
      r_csum <= '0;
    end else if (r_state == SEND && w_hs) begin
      r_csum <= r_csum ^ w_cur_byte;
    end
  end
`endif

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Self-checking bench for reg_dump_sequencer: scoreboard of expected TX bytes plus control checks.
module tb_reg_dump_sequencer;

  localparam int NRegs = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int ExtraBytes = 1;
`else
  localparam int ExtraBytes = 0;
`endif
  // Edges from the one sampling i_start to o_done high.
  localparam int DoneLat = 6 * NRegs + ExtraBytes;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        halted = 1'b0;
  logic [4:0]  rs_pipe = '0;
  logic [31:0] rf [NRegs];
  logic [31:0] read_data;
  logic [4:0]  read_reg;
  logic        pipe_grant, busy, done, abort_p;

  reg_dump_sequencer_if #(.NB_BYTE(8)) tx_if ();

  reg_dump_sequencer dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_start      (start),
    .i_halted     (halted),
    .i_rs_pipe    (rs_pipe),
    .i_read_data  (read_data),
    .o_read_reg   (read_reg),
    .o_pipe_grant (pipe_grant),
    .tx_if        (tx_if),
    .o_busy       (busy),
    .o_done       (done),
    .o_abort      (abort_p)
  );

  assign read_data = rf[read_reg];

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_done = 0;
  int   n_abort = 0;
  int   tb_bytes = 0;
  bit   bp_mode = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ready driver: always high, or pseudo-random under backpressure.
  initial begin
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_if.tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: handshake values are stable at the negedge and complete on the next posedge.
  always @(negedge clk) begin
    if (done || abort_p) check_eq("done_abort_excl", {31'b0, done & abort_p}, 32'd0);
    if (done) n_done++;
    if (abort_p) n_abort++;
    if (bp_mode && prev_stall) begin
      check_eq("hold_valid", {31'b0, tx_if.tx_valid}, 32'd1);
      check_eq("hold_data", {24'b0, tx_if.tx_data}, {24'b0, prev_data});
    end
    prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
    prev_data  = tx_if.tx_data;
    if (tx_if.tx_valid && tx_if.tx_ready) begin
      tb_bytes++;
      if (exp_q.size() == 0) check_eq("extra_byte", exp_q.size(), 32'd1);
      else check_eq("tx_byte", {24'b0, tx_if.tx_data}, {24'b0, exp_q.pop_front()});
    end
  end

  task automatic push_regs();
    for (int r = 0; r < NRegs; r++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(rf[r][8*b +: 8]);
  endtask

  task automatic push_dump();
    logic [7:0] x;
    x = '0;
    push_regs();
    for (int r = 0; r < NRegs; r++) x ^= rf[r][31:24] ^ rf[r][23:16] ^ rf[r][15:8] ^ rf[r][7:0];
`ifdef REG_DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  // Leaves the caller #1 after the edge that samples start.
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 4000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (tb_bytes < n && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("bytes_reached", tb_bytes, n);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_valid"}, {31'b0, tx_if.tx_valid}, 32'd0);
    check_eq({tag, "_data"}, {24'b0, tx_if.tx_data}, 32'd0);
    check_eq({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'b0, done}, 32'd0);
    check_eq({tag, "_abort"}, {31'b0, abort_p}, 32'd0);
    check_eq({tag, "_grant"}, {31'b0, pipe_grant}, 32'd1);
  endtask

  initial begin
    int lat;
    int done0, abort0;
    bit saw_valid, saw_busy;

    for (int r = 0; r < NRegs; r++) rf[r] = 32'h0000_0100 * r + r;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;

    // Passthrough: start without halted is ignored
    rs_pipe = 5'd9;
    start = 1'b1;
    saw_valid = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 2) start = 1'b0;
      if (tx_if.tx_valid) saw_valid = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    check_eq("pass_read_reg", {27'b0, read_reg}, 32'd9);
    check_eq("pass_grant", {31'b0, pipe_grant}, 32'd1);
    check_eq("pass_no_valid", {31'b0, saw_valid}, 32'd0);
    check_eq("pass_no_busy", {31'b0, saw_busy}, 32'd0);

    // Full dump, ready high
    halted = 1'b1;
    tb_bytes = 0;
    push_dump();
    pulse_start();
    check_eq("select_grant", {31'b0, pipe_grant}, 32'd0);
    check_eq("select_read_reg", {27'b0, read_reg}, 32'd0);
    wait_done(lat);
    check_eq("done_latency", lat, DoneLat);
    repeat (3) @(posedge clk);
    #1;
    check_eq("full_bytes", tb_bytes, 4 * NRegs + ExtraBytes);
    check_eq("full_q_empty", exp_q.size(), 32'd0);
    check_eq("full_done_cnt", n_done, 32'd1);
    check_eq("full_grant_back", {31'b0, pipe_grant}, 32'd1);

    // Backpressure
    bp_mode = 1'b1;
    tb_bytes = 0;
    push_dump();
    pulse_start();
    wait_done(lat);
    repeat (3) @(posedge clk);
    #1;
    bp_mode = 1'b0;
    check_eq("bp_bytes", tb_bytes, 4 * NRegs + ExtraBytes);
    check_eq("bp_q_empty", exp_q.size(), 32'd0);
    check_eq("bp_done_cnt", n_done, 32'd2);

    // Abort after byte 10, then restart from reg 0
    repeat (2) @(posedge clk);
    tb_bytes = 0;
    done0 = n_done;
    push_dump();
    pulse_start();
    wait_bytes(10);
    halted = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_pulse", {31'b0, abort_p}, 32'd1);
    check_eq("abort_grant", {31'b0, pipe_grant}, 32'd1);
    check_eq("abort_valid", {31'b0, tx_if.tx_valid}, 32'd0);
    @(posedge clk);
    #1;
    check_eq("abort_one_cycle", {31'b0, abort_p}, 32'd0);
    check_eq("abort_sent", tb_bytes, 32'd10);
    check_eq("abort_no_done", n_done, done0);
    check_eq("abort_cnt", n_abort, 32'd1);
    exp_q.delete();
    halted = 1'b1;
    tb_bytes = 0;
    push_dump();
    pulse_start();
    wait_done(lat);
    repeat (2) @(posedge clk);
    #1;
    check_eq("restart_q_empty", exp_q.size(), 32'd0);
    check_eq("restart_bytes", tb_bytes, 4 * NRegs + ExtraBytes);

    // Reset mid-dump at byte 50
    tb_bytes = 0;
    done0 = n_done;
    abort0 = n_abort;
    push_dump();
    pulse_start();
    wait_bytes(50);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle_outputs("midrst");
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check_eq("midrst_no_done", n_done, done0);
    check_eq("midrst_no_abort", n_abort, abort0);

`ifdef REG_DUMP_CHECKSUM_EN
    // Checksum byte
    for (int r = 0; r < NRegs; r++) rf[r] = 32'hA5A5_A5A5;
    push_regs();
    exp_q.push_back(8'h00);
    pulse_start();
    wait_done(lat);
    repeat (2) @(posedge clk);
    #1;
    check_eq("csum0_q_empty", exp_q.size(), 32'd0);
    rf[1] = 32'h0000_0001;
    push_regs();
    exp_q.push_back(8'h01);
    pulse_start();
    wait_done(lat);
    repeat (2) @(posedge clk);
    #1;
    check_eq("csum1_q_empty", exp_q.size(), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
